// File: rtl/serial_parallel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_parallel_pkg
// Description : Shared constants for the serial-to-parallel frame assembler.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_parallel_pkg;

    localparam int c_D_WL_DEFAULT      = 24;
    localparam int c_CLASS_NUM_DEFAULT = 2;
    localparam int c_CNT_W             = 8;

endpackage : serial_parallel_pkg
`default_nettype wire

// File: rtl/serial_parallel.sv
`default_nettype none
// ============================================================================
// Module      : serial_parallel
// Description : Collects CLASS_NUM serial words into one registered frame,
//               first word in the LSB slice, with a one-cycle o_valid pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_parallel
    import serial_parallel_pkg::*;
#(
    parameter int D_WL      = c_D_WL_DEFAULT,
    parameter int CLASS_NUM = c_CLASS_NUM_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [D_WL-1:0]           D_IN,
    input  logic                      i_valid,
    input  logic                      clear,
    output logic [CLASS_NUM*D_WL-1:0] out,
    output logic                      o_valid,
    output logic                      busy
);

    localparam int                 c_FRAME_W = CLASS_NUM * D_WL;
    localparam logic [c_CNT_W-1:0] c_LAST    = c_CNT_W'(CLASS_NUM - 1);
    localparam logic [c_CNT_W-1:0] c_ONE     = c_CNT_W'(1);

    logic [c_FRAME_W-1:0] r_shift;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_FRAME_W-1:0] r_out;
    logic                 r_o_valid;

    logic                 w_accept;
    logic                 w_last;
    logic [c_FRAME_W-1:0] w_shift_next;

    // clear wins over a same-cycle word, which is simply dropped
    assign w_accept     = i_valid & ~clear;
    assign w_last       = w_accept & (r_cnt == c_LAST);
    assign w_shift_next = {D_IN, r_shift[c_FRAME_W-1:D_WL]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift   <= '0;
            r_cnt     <= '0;
            r_out     <= '0;
            r_o_valid <= 1'b0;
        end else begin
            r_o_valid <= w_last;
            if (clear) begin
                r_shift <= '0;
                r_cnt   <= '0;
            end else if (w_accept) begin
                r_shift <= w_shift_next;
                r_cnt   <= w_last ? '0 : r_cnt + c_ONE;
            end
            // the shifted value already holds the whole frame on the last word
            if (w_last) begin
                r_out <= w_shift_next;
            end
        end
    end

    assign out     = r_out;
    assign o_valid = r_o_valid;
    assign busy    = (r_cnt != '0);

endmodule : serial_parallel
`default_nettype wire

// File: tb/tb_serial_parallel.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_parallel
// Description : Scoreboard bench for serial_parallel (D_WL=24, CLASS_NUM=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_parallel;

    localparam int c_D_WL      = 24;
    localparam int c_CLASS_NUM = 2;
    localparam int c_FRAME_W   = c_D_WL * c_CLASS_NUM;

    logic                 clk;
    logic                 rst_n;
    logic [c_D_WL-1:0]    D_IN;
    logic                 i_valid;
    logic                 clear;
    logic [c_FRAME_W-1:0] out;
    logic                 o_valid;
    logic                 busy;

    int n_total = 0;
    int n_bad   = 0;
    int n_frames = 0;

    logic [c_FRAME_W-1:0] exp_q[$];
    logic [c_FRAME_W-1:0] m_acc;
    logic [c_FRAME_W-1:0] m_last;
    int                   m_cnt;

    serial_parallel #(
        .D_WL      (c_D_WL),
        .CLASS_NUM (c_CLASS_NUM)
    ) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .D_IN    (D_IN),
        .i_valid (i_valid),
        .clear   (clear),
        .out     (out),
        .o_valid (o_valid),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h want=0x%0h", tag, act, exp);
        end
    endtask

    // One cycle of stimulus; the model places word k at slice k directly
    task automatic drive_word(input logic [c_D_WL-1:0] w, input logic clr);
        @(negedge clk);
        D_IN    = w;
        i_valid = 1'b1;
        clear   = clr;
        if (clr) begin
            m_cnt = 0;
            m_acc = '0;
        end else begin
            m_acc[m_cnt*c_D_WL +: c_D_WL] = w;
            m_cnt++;
            if (m_cnt == c_CLASS_NUM) begin
                exp_q.push_back(m_acc);
                m_cnt = 0;
                m_acc = '0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            i_valid = 1'b0;
            clear   = 1'b0;
            D_IN    = '0;
        end
    endtask

    // Monitor: pop on every o_valid, otherwise out must hold the last frame
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            chk("busy", {63'd0, busy}, {63'd0, (m_cnt != 0)});
            if (o_valid) begin
                n_frames++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_o_valid", out, 64'hDEAD_0000_0000);
                end else begin
                    m_last = exp_q.pop_front();
                    chk("frame", out, m_last);
                end
            end else begin
                chk("out_hold", out, m_last);
            end
        end
    end

    initial begin
        rst_n   = 1'b0;
        D_IN    = '0;
        i_valid = 1'b0;
        clear   = 1'b0;
        m_acc   = '0;
        m_last  = '0;
        m_cnt   = 0;

        #12;
        chk("rst_out", out, 64'd0);
        chk("rst_o_valid", {63'd0, o_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // two consecutive words
        drive_word(24'h000011, 1'b0);
        drive_word(24'h000022, 1'b0);
        idle(3);

        // gap inside a frame keeps busy high
        drive_word(24'h0000AA, 1'b0);
        idle(1);
        @(posedge clk); #2;
        chk("gap_busy", {63'd0, busy}, 64'd1);
        idle(2);
        drive_word(24'h0000BB, 1'b0);
        idle(3);

        // back-to-back frames
        drive_word(24'h000001, 1'b0);
        drive_word(24'h000002, 1'b0);
        drive_word(24'h000003, 1'b0);
        drive_word(24'h000004, 1'b0);
        idle(3);

        // clear drops the partial frame and the same-cycle word
        drive_word(24'h111111, 1'b0);
        drive_word(24'h222222, 1'b1);
        drive_word(24'h333333, 1'b0);
        drive_word(24'h444444, 1'b0);
        idle(3);

        // asynchronous reset in the middle of a frame
        drive_word(24'h555555, 1'b0);
        @(posedge clk);
        #3;
        i_valid = 1'b0;
        rst_n   = 1'b0;
        m_cnt   = 0;
        m_acc   = '0;
        m_last  = '0;
        #1;
        chk("mid_rst_out", out, 64'd0);
        chk("mid_rst_o_valid", {63'd0, o_valid}, 64'd0);
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive_word(24'h00000A, 1'b0);
        drive_word(24'h00000B, 1'b0);
        idle(4);

        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        chk("frame_count", 64'(n_frames), 64'd6);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_serial_parallel
`default_nettype wire

// File: doc/serial_parallel.md
SERIAL_PARALLEL -- requirements
Module: serial_parallel

Interface
REQ-001 SHALL have parameter D_WL, default 24, width in bits of one serial word.
REQ-002 SHALL have parameter CLASS_NUM, default 2, words per frame; legal range 2..255.
REQ-003 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port D_IN, input, D_WL, serial word.
REQ-006 SHALL have port i_valid, input, 1, D_IN holds a valid word this cycle.
REQ-007 SHALL have port clear, input, 1, synchronous abort of the partial frame.
REQ-008 SHALL have port out, output, CLASS_NUM*D_WL, assembled frame, registered.
REQ-009 SHALL have port o_valid, output, 1, one-cycle pulse marking a new frame on out.
REQ-010 SHALL have port busy, output, 1, high while a partial frame is held (cnt != 0).

Function
REQ-011 SHALL place the k-th accepted word of a frame (k = 0 first) at out[k*D_WL +: D_WL], so the first word lands in the LSB slice.
REQ-012 SHALL accept one word per cycle when i_valid=1, with no backpressure; idle gaps of any length between words SHALL NOT alter the frame.
REQ-013 SHALL assemble words in a CLASS_NUM*D_WL shift register: on accept, shift right by D_WL and insert D_IN in the top slice.
REQ-014 SHALL keep an 8-bit word counter cnt, reset 0, incremented on each accept, wrapping to 0 after the word with cnt=CLASS_NUM-1.
REQ-015 SHALL, when the last word is accepted in cycle t, present the full frame on out and o_valid=1 in cycle t+1 (latency 1 from the last word).
REQ-016 SHALL hold o_valid high for exactly one cycle per completed frame.
REQ-017 SHALL hold out stable between completions; partial frames SHALL NOT be visible on out.
REQ-018 SHALL support back-to-back frames: the word after the last word starts a new frame with cnt=0 in the same cycle the previous frame's o_valid is high.
REQ-019 SHALL, on clear=1, set cnt=0 and zero the shift register next cycle; out and any o_valid already scheduled SHALL be unaffected.
REQ-020 SHALL give clear priority over i_valid in the same cycle: the word is discarded.
REQ-021 SHALL drive busy combinationally as (cnt != 0).

Reset
REQ-022 SHALL, while rst_n=0, asynchronously force out=0, o_valid=0, cnt=0, and the shift register to 0.
REQ-023 SHALL discard any partial frame on reset mid-frame; the first word accepted after reset release is word 0.

Structure
REQ-024 SHALL place the D_WL and CLASS_NUM defaults and the counter width (8) in the shared package as constants.
REQ-025 SHALL be a single module with no sub-module; the shift register, counter and output register are inline.

Verification (D_WL=24, CLASS_NUM=2)
REQ-026 SHALL check: i_valid on 2 consecutive cycles with 0x000011 then 0x000022 -> next cycle o_valid=1 for one cycle, out=0x000022000011.
REQ-027 SHALL check: 0x0000AA, 3 idle cycles, then 0x0000BB -> single o_valid after BB, out=0x0000BB0000AA; busy=1 during the gap.
REQ-028 SHALL check: 4 consecutive words 1,2,3,4 -> o_valid pulses 2 cycles apart, out=0x000002000001 then 0x000004000003.
REQ-029 SHALL check: word 0x111111, clear=1 with i_valid=1 on 0x222222, then 0x333333 and 0x444444 -> out=0x444444333333; no o_valid before that.
REQ-030 SHALL check: rst_n low after one word -> out=0, o_valid=0, busy=0 immediately; the next two words 0x00000A and 0x00000B -> out=0x00000B00000A.
